// File: rtl/sort_net_pipe_if.sv
// sort_net_pipe_if: valid/ready bus for the pipelined sorting network.
//
// Signals:
//   in_valid / in_ready / in_data    : producer -> sorter handshake, N packed words
//   out_valid / out_ready / out_data : sorter -> consumer handshake, N packed words
//   out_index                        : original input lane of each output word
//                                      (present only when SORT_INDEX_EN is defined)
// Modports:
//   master : the producer/consumer side (drives in_*, out_ready)
//   slave  : the sorter itself
interface sort_net_pipe_if #(
    parameter int N     = 8,
    parameter int WIDTH = 32
);
    localparam int IDX_W = $clog2(N);

    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [N*WIDTH-1:0] out_data;
`ifdef SORT_INDEX_EN
    logic [N*IDX_W-1:0] out_index;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_index);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_index);
`else
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/sort_net_pipe.sv
// sort_net_pipe: fully pipelined odd-even transposition sorting network.
//
// N compare layers, each followed by a register stage. Stage 0 captures the
// incoming vector, stage N drives the output, so a vector accepted at edge t
// is presented after edge t+N when nothing stalls. Words compare as unsigned;
// equal words never swap, so the sort is stable.
//
// Parameters: N (2..32 words), WIDTH (bits per word), DESCENDING (0 = lane 0
// smallest, 1 = lane 0 largest).
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears every stage
//   bus : sort_net_pipe_if.slave (in_valid/in_ready/in_data,
//         out_valid/out_ready/out_data[, out_index])
//
// Optional feature macro: SORT_INDEX_EN -- when defined, each word carries
// its original lane index through the network and it is driven on out_index.
module sort_net_pipe #(
    parameter int N          = 8,
    parameter int WIDTH      = 32,
    parameter int DESCENDING = 0
) (
    input logic           clk,
    input logic           rst,
    sort_net_pipe_if.slave bus
);
    localparam int IDX_W = $clog2(N);

    typedef logic [WIDTH-1:0] word_t;

    logic [N:0] stage_valid;
    word_t      stage_data [0:N][0:N-1];
    word_t      layer_data [0:N-1][0:N-1];
    logic       stall;

`ifdef SORT_INDEX_EN
    typedef logic [IDX_W-1:0] idx_t;
    idx_t stage_idx [0:N][0:N-1];
    idx_t layer_idx [0:N-1][0:N-1];
`endif

    function automatic logic needs_swap(input word_t lo, input word_t hi);
        if (DESCENDING != 0) return lo < hi;
        else                 return lo > hi;
    endfunction

    // A full output register that the consumer refuses freezes the whole
    // pipeline; in_ready is its complement, so accept == in_valid when open.
    assign stall         = stage_valid[N] & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = stage_valid[N];

    // Compare-exchange layers. Even layers pair (0,1),(2,3)...; odd layers
    // pair (1,2),(3,4)...; any lane left without a partner passes straight.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                layer_data[k][i] = stage_data[k][i];
`ifdef SORT_INDEX_EN
                layer_idx[k][i]  = stage_idx[k][i];
`endif
            end
            for (int i = 0; i < N - 1; i++) begin
                if ((i % 2) == (k % 2)) begin
                    if (needs_swap(stage_data[k][i], stage_data[k][i+1])) begin
                        layer_data[k][i]   = stage_data[k][i+1];
                        layer_data[k][i+1] = stage_data[k][i];
`ifdef SORT_INDEX_EN
                        layer_idx[k][i]    = stage_idx[k][i+1];
                        layer_idx[k][i+1]  = stage_idx[k][i];
`endif
                    end
                end
            end
        end
    end

    // Stage registers share one enable so bubbles and data shift together.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
            for (int s = 0; s <= N; s++) begin
                for (int i = 0; i < N; i++) begin
                    stage_data[s][i] <= '0;
`ifdef SORT_INDEX_EN
                    stage_idx[s][i]  <= '0;
`endif
                end
            end
        end else if (!stall) begin
            stage_valid <= {stage_valid[N-1:0], bus.in_valid};
            for (int i = 0; i < N; i++) begin
                stage_data[0][i] <= bus.in_data[i*WIDTH +: WIDTH];
`ifdef SORT_INDEX_EN
                stage_idx[0][i]  <= IDX_W'(i);
`endif
            end
            for (int s = 0; s < N; s++) begin
                for (int i = 0; i < N; i++) begin
                    stage_data[s+1][i] <= layer_data[s][i];
`ifdef SORT_INDEX_EN
                    stage_idx[s+1][i]  <= layer_idx[s][i];
`endif
                end
            end
        end
    end

    // Repack the output stage into the same lane layout as in_data.
    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < N; i++) begin
            bus.out_data[i*WIDTH +: WIDTH] = stage_data[N][i];
        end
    end

`ifdef SORT_INDEX_EN
    always_comb begin
        bus.out_index = '0;
        for (int i = 0; i < N; i++) begin
            bus.out_index[i*IDX_W +: IDX_W] = stage_idx[N][i];
        end
    end
`endif

endmodule

// File: doc/sort_net_pipe.md
Name: sort_net_pipe

Overview:
- Parametrised, fully pipelined sorting network for N unsigned words. Uses an odd-even transposition network with one register stage per compare layer.
- Successor to the fixed 3-input combinational sorters. Adds generic N/WIDTH, a sort-direction parameter, valid/ready flow control, and a fixed known latency.
- Sits between a producer of packed word vectors and a consumer that needs them ordered.
- Accepts one vector per cycle when not stalled.

Parameters:
N, 8, number of words per vector; legal range 2..32.
WIDTH, 32, bits per word; compared as unsigned.
DESCENDING, 0, 0 = ascending (lane 0 smallest), 1 = descending (lane 0 largest).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data holds a vector to sort.
in_ready  output  1  pipeline can accept a vector this cycle.
in_data  input  N*WIDTH  packed input; word i = in_data[i*WIDTH +: WIDTH].
out_valid  output  1  out_data holds a sorted vector.
out_ready  input  1  consumer accepts out_data this cycle.
out_data  output  N*WIDTH  packed sorted output, same lane packing as in_data.

Behaviour:
- Reset: rst is sampled high at a clk edge.
  - All stage valid bits, out_valid and all pipeline data registers clear to 0.
  - in_ready is 1 in the cycle after reset.
  - A reset mid-operation discards all in-flight vectors; no partial output is produced.
- Network: N compare layers, numbered k = 0..N-1.
  - Even k compares pairs (0,1), (2,3), ...
  - Odd k compares pairs (1,2), (3,4), ...
  - An unpaired edge lane passes through unchanged; this occurs for odd N and on odd layers.
- Compare-exchange:
  - Ascending: swap only if lower lane > upper lane.
  - Descending: swap only if lower lane < upper lane.
  - Equal words never swap, so the network is stable.
- Pipelining:
  - Layer k output is registered into stage k+1. Stage N is the output register that drives out_data/out_valid.
  - Each stage holds a valid bit plus N words.
- Latency: a vector accepted at edge t appears with out_valid=1 after edge t+N, provided no stall occurs in between.
- Flow control: stall = out_valid & ~out_ready.
  - in_ready = ~stall, purely combinational from out_valid and out_ready.
  - Accept occurs when in_valid & in_ready.
  - While stall=1, every stage register holds its value (global enable); out_data and out_valid are stable.
  - While not stalled, every stage advances one step per cycle. Bubbles (valid=0) propagate like data.
- Throughput: 1 vector/cycle with out_ready held high.
- Simultaneous events:
  - Accept at stage 0 and drain at the output in the same cycle is legal; the pipeline shifts.
  - in_valid=1 with in_ready=0 does not capture; the producer must hold its data.
- Data contents of invalid stages are don't-care. out_data is checked only while out_valid=1.
- Arithmetic: no sign extension, no width change; output words are a permutation of input words.
- Ordering: vectors leave in the order they were accepted.

Optional Feature:
SORT_INDEX_EN
- Defined: an extra output port out_index, width N*$clog2(N), is added.
  - Each word carries its original lane index through every compare-exchange.
  - out_index lane j gives the input lane of out_data word j.
  - Indices are registered and stalled identically to the data.
  - Ties keep input order, e.g. equal words from lanes 1 and 3 appear with index 1 before 3.
- Undefined: the port and index registers do not exist; all other behaviour is identical.

Test Plan:
- Reset/latency (N=4, WIDTH=8, ascending): rst high 2 cycles, then one vector {3,1,4,1} (lanes 0..3) with out_ready=1.
  - Required: out_valid=0 until exactly 4 cycles after accept, then out_data {1,1,3,4} for 1 cycle.
- Descending (N=4): input {0x10,0xFF,0x00,0x7F}.
  - Required: out_data {0xFF,0x7F,0x10,0x00}.
- Streaming (N=5, odd): 100 back-to-back random vectors with out_ready=1.
  - Required: 100 outputs, in order, each sorted and a permutation of its input.
  - Required: in_ready stays 1 throughout.
- Backpressure: stream 10 vectors while holding out_ready=0 for 7 cycles once out_valid rises.
  - Required: out_data frozen and in_ready=0 during the hold; no vector lost or duplicated.
- Reset mid-flight: accept 3 vectors, assert rst one cycle before the first would emerge.
  - Required: out_valid stays 0 for N cycles after reset; the next accepted vector emerges correctly.
- SORT_INDEX_EN (N=4): input {5,2,5,2}.
  - Required: out_data {2,2,5,5}, out_index {1,3,0,2}.
